sdram_req_queue: RTL and testbench

Request queue between the GPMC register file and sdram_controller, in the single SDRAM clock domain.
- Accepts write/read requests with a valid/ready handshake and buffers them in a command FIFO.
- Issues requests one at a time using the controller's enable/busy protocol.
- Captures read data on rd_ready into a read-data FIFO that the GPMC side pops.
- Replaces direct register-bit driving of wr_enable/rd_enable.

---
 rtl/sdram_req_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/sdram_req_queue.sv | 191 +++++++++++++++++++
 tb/tb_sdram_req_queue.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_req_pkg.sv
// sdram_req_pkg
// Shared definitions for the SDRAM request queue: issue FSM state encoding,
// default geometry and the width of one command FIFO entry.
// No ports (package).
package sdram_req_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_WAIT_DATA = 2'd3
   } state_t;

   localparam int ADDR_WIDTH_DEF     = 25;
   localparam int DATA_WIDTH_DEF     = 8;
   localparam int CMD_DEPTH_LOG2_DEF = 2;
   localparam int RD_DEPTH_LOG2_DEF  = 2;
   localparam int ACK_TIMEOUT_DEF    = 15;

   // Command entry layout is {write, addr, wdata}.
   function automatic int cmd_entry_width(input int addr_w, input int data_w);
      return 1 + addr_w + data_w;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock show-ahead FIFO with 2^DEPTH_LOG2 entries.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (empties the FIFO)
//   push, din      write request and data (accepted when not full, or when
//                  full together with a pop)
//   pop            read request (ignored when empty)
//   dout           head entry, zero while empty
//   full, empty    status flags
//   level          occupancy, 0 .. 2^DEPTH_LOG2
module sync_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [WIDTH-1:0]      din,
   input  logic                  pop,
   output logic [WIDTH-1:0]      dout,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   level
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [WIDTH-1:0]    mem [DEPTH];
   logic [DEPTH_LOG2:0] wr_ptr;
   logic [DEPTH_LOG2:0] rd_ptr;
   logic                do_push;
   logic                do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                  (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
   assign level = wr_ptr - rd_ptr;

   assign do_pop  = pop && !empty;
   // A push into a full FIFO is fine when the head leaves in the same edge.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
   end

   // Stale storage is masked so the head reads zero whenever nothing is queued.
   assign dout = empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];

endmodule

// File: rtl/sdram_req_queue.sv
// sdram_req_queue
// Buffers GPMC read/write requests and issues them one at a time to
// sdram_controller using its enable/busy protocol; read data returned on
// sd_rd_ready is queued for the GPMC side to pop.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid/req_ready              request handshake (ready = command FIFO not full)
//   req_write, req_addr, req_wdata   request contents (wdata unused for reads)
//   rdq_valid, rdq_pop, rdq_data     read-data FIFO head, show-ahead
//   sd_addr, sd_wr_data              address/data of the command in flight
//   sd_wr_enable, sd_rd_enable       controller enables, high only while issuing
//   sd_busy, sd_rd_ready, sd_rd_data controller status and read return
//   cmd_level                        command FIFO occupancy
//   idle                             nothing queued and nothing in flight
//   err_timeout                      sticky: an issued command was never acknowledged
//   err_overflow                     sticky: request offered while not ready
module sdram_req_queue
   import sdram_req_pkg::*;
#(
   parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int CMD_DEPTH_LOG2 = CMD_DEPTH_LOG2_DEF,
   parameter int RD_DEPTH_LOG2  = RD_DEPTH_LOG2_DEF,
   parameter int ACK_TIMEOUT    = ACK_TIMEOUT_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [ADDR_WIDTH-1:0]     req_addr,
   input  logic [DATA_WIDTH-1:0]     req_wdata,
   output logic                      rdq_valid,
   input  logic                      rdq_pop,
   output logic [DATA_WIDTH-1:0]     rdq_data,
   output logic [ADDR_WIDTH-1:0]     sd_addr,
   output logic [DATA_WIDTH-1:0]     sd_wr_data,
   output logic                      sd_wr_enable,
   output logic                      sd_rd_enable,
   input  logic                      sd_busy,
   input  logic                      sd_rd_ready,
   input  logic [DATA_WIDTH-1:0]     sd_rd_data,
   output logic [CMD_DEPTH_LOG2:0]   cmd_level,
   output logic                      idle,
   output logic                      err_timeout,
   output logic                      err_overflow
);

   localparam int CMD_W = cmd_entry_width(ADDR_WIDTH, DATA_WIDTH);
   localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
   localparam logic [RD_DEPTH_LOG2:0] RD_LEVEL_MAX = (RD_DEPTH_LOG2 + 1)'(1 << RD_DEPTH_LOG2);

   state_t                  state;
   state_t                  state_nxt;

   logic                    cmd_push;
   logic                    cmd_pop;
   logic                    cmd_full;
   logic                    cmd_empty;
   logic [CMD_W-1:0]        cmd_head;
   logic                    head_write;
   logic [ADDR_WIDTH-1:0]   head_addr;
   logic [DATA_WIDTH-1:0]   head_wdata;

   logic                    rd_push;
   logic                    rd_full;
   logic                    rd_empty;
   logic [RD_DEPTH_LOG2:0]  rd_level;

   logic                    cur_write;
   logic                    rd_captured;
   logic [TMR_W-1:0]        timer;
   logic                    timeout_hit;
   logic                    read_outstanding;

   assign req_ready = !cmd_full;
   assign cmd_push  = req_valid && req_ready;

   sync_fifo #(
      .WIDTH      (CMD_W),
      .DEPTH_LOG2 (CMD_DEPTH_LOG2)
   ) u_cmd_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cmd_push),
      .din   ({req_write, req_addr, req_wdata}),
      .pop   (cmd_pop),
      .dout  (cmd_head),
      .full  (cmd_full),
      .empty (cmd_empty),
      .level (cmd_level)
   );

   assign {head_write, head_addr, head_wdata} = cmd_head;

   // A read stays outstanding from issue until the FSM is back in IDLE; a
   // data strobe arriving in that window is captured, anything else is stray.
   assign read_outstanding = !cur_write && (state != ST_IDLE);
   assign rd_push          = sd_rd_ready && read_outstanding;

   sync_fifo #(
      .WIDTH      (DATA_WIDTH),
      .DEPTH_LOG2 (RD_DEPTH_LOG2)
   ) u_rd_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (rd_push),
      .din   (sd_rd_data),
      .pop   (rdq_pop),
      .dout  (rdq_data),
      .full  (rd_full),
      .empty (rd_empty),
      .level (rd_level)
   );

   assign rdq_valid = !rd_empty;

   // Reads are only issued with a free slot and one at a time, so a capture
   // can never land on a full read FIFO unless the head is popped alongside.
   always_ff @(posedge clk) begin
      if (rst_n && rd_push) assert (rd_level < RD_LEVEL_MAX || rdq_pop);
   end

   always_comb begin
      state_nxt   = state;
      cmd_pop     = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!cmd_empty && !sd_busy && (head_write || !rd_full)) begin
               cmd_pop   = 1'b1;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (sd_busy) begin
               state_nxt = ST_WAIT_DONE;
            end else if (timer == TMR_LAST) begin
               timeout_hit = 1'b1;
               state_nxt   = ST_IDLE;
            end
         end
         ST_WAIT_DONE: begin
            // The controller may strobe read data before (or as) busy falls;
            // in that case there is nothing left to wait for.
            if (!sd_busy) begin
               if (cur_write || rd_captured || rd_push) state_nxt = ST_IDLE;
               else                                      state_nxt = ST_WAIT_DATA;
            end
         end
         ST_WAIT_DATA: begin
            if (sd_rd_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         cur_write    <= 1'b0;
         rd_captured  <= 1'b0;
         timer        <= '0;
         sd_addr      <= '0;
         sd_wr_data   <= '0;
         err_timeout  <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         state <= state_nxt;
         if (cmd_pop) begin
            // Address/data are held from here until the next issue.
            cur_write   <= head_write;
            sd_addr     <= head_addr;
            sd_wr_data  <= head_wdata;
            rd_captured <= 1'b0;
            timer       <= '0;
         end else begin
            if (state == ST_ISSUE) timer <= timer + 1'b1;
            if (rd_push)           rd_captured <= 1'b1;
         end
         if (timeout_hit)             err_timeout  <= 1'b1;
         if (req_valid && !req_ready) err_overflow <= 1'b1;
      end
   end

   assign sd_wr_enable = (state == ST_ISSUE) &&  cur_write;
   assign sd_rd_enable = (state == ST_ISSUE) && !cur_write;
   assign idle         = cmd_empty && (state == ST_IDLE);

endmodule

// File: tb/tb_sdram_req_queue.sv
// tb_sdram_req_queue
// Directed bench for sdram_req_queue. Expected issued commands and expected
// read data are queued as stimulus is applied; a monitor compares them as the
// DUT raises an enable or the bench pops read data. A small controller model
// answers enables with a 5-cycle busy window and, for reads, a data strobe.
module tb_sdram_req_queue;

   localparam int AW = 25;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_write = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          rdq_valid;
   logic          rdq_pop = 1'b0;
   logic [DW-1:0] rdq_data;
   logic [AW-1:0] sd_addr;
   logic [DW-1:0] sd_wr_data;
   logic          sd_wr_enable;
   logic          sd_rd_enable;
   logic          sd_busy;
   logic          sd_rd_ready;
   logic [DW-1:0] sd_rd_data;
   logic [2:0]    cmd_level;
   logic          idle;
   logic          err_timeout;
   logic          err_overflow;

   int checks = 0;
   int errors = 0;
   int issue_cnt = 0;

   logic [AW+DW:0] exp_cmd [$];
   logic [DW-1:0]  exp_rd  [$];
   logic [DW-1:0]  ret_q   [$];

   // controller model controls
   logic hold_busy   = 1'b0;
   logic ack_en      = 1'b1;
   logic rd_suppress = 1'b0;
   int   busy_cnt    = 0;
   logic pend_rd     = 1'b0;
   logic rd_due      = 1'b0;

   sdram_req_queue dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rdq_valid    (rdq_valid),
      .rdq_pop      (rdq_pop),
      .rdq_data     (rdq_data),
      .sd_addr      (sd_addr),
      .sd_wr_data   (sd_wr_data),
      .sd_wr_enable (sd_wr_enable),
      .sd_rd_enable (sd_rd_enable),
      .sd_busy      (sd_busy),
      .sd_rd_ready  (sd_rd_ready),
      .sd_rd_data   (sd_rd_data),
      .cmd_level    (cmd_level),
      .idle         (idle),
      .err_timeout  (err_timeout),
      .err_overflow (err_overflow)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Controller model: acts just after each rising edge.
   initial begin
      sd_busy     = 1'b0;
      sd_rd_ready = 1'b0;
      sd_rd_data  = '0;
      forever begin
         @(posedge clk);
         #1;
         sd_rd_ready = 1'b0;
         if (rd_due && !rd_suppress) begin
            sd_rd_ready = 1'b1;
            sd_rd_data  = 8'h00;
            if (ret_q.size() > 0) sd_rd_data = ret_q.pop_front();
            rd_due = 1'b0;
         end
         if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0 && pend_rd) begin
               rd_due  = 1'b1;
               pend_rd = 1'b0;
            end
         end else if (ack_en && (sd_wr_enable || sd_rd_enable)) begin
            busy_cnt = 5;
            pend_rd  = sd_rd_enable;
         end
         sd_busy = hold_busy || (busy_cnt > 0);
      end
   end

   // Monitor: compares issued commands and popped read data with the queues.
   initial begin
      logic          prev_en;
      logic          en;
      logic [AW+DW:0] e;
      prev_en = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         en = sd_wr_enable | sd_rd_enable;
         if (!rst_n) begin
            prev_en = 1'b0;
         end else begin
            if (en && !prev_en) begin
               issue_cnt++;
               chk("single_enable", 64'(sd_wr_enable & sd_rd_enable), 64'd0);
               if (exp_cmd.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL issue_unexpected: got cmd 0x%0h, expected no issue",
                           {sd_wr_enable, sd_addr, sd_wr_data});
               end else begin
                  e = exp_cmd.pop_front();
                  chk("issue_cmd", 64'({sd_wr_enable, sd_addr, sd_wr_data}), 64'(e));
               end
            end
            if (rdq_pop && rdq_valid) begin
               if (exp_rd.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL rdq_unexpected: got 0x%0h, expected no data", rdq_data);
               end else begin
                  chk("rdq_data", 64'(rdq_data), 64'(exp_rd.pop_front()));
               end
            end
            prev_en = en;
         end
      end
   end

   // Called on a falling edge; offers one request for one cycle.
   task automatic drive_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      if (req_ready) exp_cmd.push_back({w, a, d});
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic pop_rd();
      rdq_pop = 1'b1;
      @(negedge clk);
      rdq_pop = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget && !idle; i++) @(negedge clk);
      chk("wait_idle", 64'(idle), 64'd1);
   endtask

   task automatic wait_issue(input int target, input int budget);
      for (int i = 0; i < budget && issue_cnt < target; i++) @(negedge clk);
      chk("issue_count", 64'(issue_cnt), 64'(target));
   endtask

   task automatic wait_rdq(input int budget);
      for (int i = 0; i < budget && !rdq_valid; i++) @(negedge clk);
      chk("rdq_valid_wait", 64'(rdq_valid), 64'd1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"},  64'(req_ready),    64'd1);
      chk({tag, "_rdq_valid"},  64'(rdq_valid),    64'd0);
      chk({tag, "_rdq_data"},   64'(rdq_data),     64'd0);
      chk({tag, "_enables"},    64'({sd_wr_enable, sd_rd_enable}), 64'd0);
      chk({tag, "_sd_addr"},    64'(sd_addr),      64'd0);
      chk({tag, "_sd_wr_data"}, 64'(sd_wr_data),   64'd0);
      chk({tag, "_cmd_level"},  64'(cmd_level),    64'd0);
      chk({tag, "_idle"},       64'(idle),         64'd1);
      chk({tag, "_errors"},     64'({err_timeout, err_overflow}), 64'd0);
   endtask

   initial begin
      int   base;
      int   cnt;
      logic saw_rd_en;
      logic bad;

      // Reset values
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Single write: enable two cycles after acceptance
      drive_req(1'b1, 25'h0000123, 8'hA5);
      chk("wr_cycle1_enable", 64'(sd_wr_enable), 64'd0);
      chk("wr_cycle1_level", 64'(cmd_level), 64'd1);
      @(negedge clk);
      chk("wr_cycle2_enable", 64'(sd_wr_enable), 64'd1);
      chk("wr_cycle2_addr", 64'(sd_addr), 64'h0000123);
      chk("wr_cycle2_data", 64'(sd_wr_data), 64'hA5);
      chk("wr_cycle2_level", 64'(cmd_level), 64'd0);
      @(negedge clk);
      chk("wr_enable_drop", 64'(sd_wr_enable), 64'd0);
      chk("wr_addr_stable", 64'(sd_addr), 64'h0000123);
      wait_idle(50);

      // Read with data returned after the busy window
      ret_q.push_back(8'h3C);
      exp_rd.push_back(8'h3C);
      drive_req(1'b0, 25'h1000000, 8'h00);
      wait_rdq(50);
      chk("rd_head", 64'(rdq_data), 64'h3C);
      pop_rd();
      chk("rd_after_pop", 64'(rdq_valid), 64'd0);
      wait_idle(50);

      // Backpressure while the controller stays busy
      hold_busy = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) drive_req(1'b1, AW'(25'h10 + i), DW'(8'h20 + i));
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_level", 64'(cmd_level), 64'd4);
      chk("bp_no_overflow_yet", 64'(err_overflow), 64'd0);
      drive_req(1'b1, 25'h14, 8'h24);
      chk("bp_overflow", 64'(err_overflow), 64'd1);
      chk("bp_level_hold", 64'(cmd_level), 64'd4);
      base = issue_cnt;
      hold_busy = 1'b0;
      wait_issue(base + 4, 100);
      wait_idle(50);

      // Read FIFO full blocks a fifth read until one entry is popped
      base = issue_cnt;
      for (int i = 0; i < 5; i++) begin
         ret_q.push_back(DW'(8'h50 + i));
         exp_rd.push_back(DW'(8'h50 + i));
         drive_req(1'b0, AW'(25'h200 + i), 8'h00);
      end
      wait_issue(base + 4, 100);
      for (int i = 0; i < 12; i++) @(negedge clk);
      saw_rd_en = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (sd_rd_enable) saw_rd_en = 1'b1;
         @(negedge clk);
      end
      chk("rdfull_no_issue", 64'(saw_rd_en), 64'd0);
      chk("rdfull_level", 64'(cmd_level), 64'd1);
      chk("rdfull_issue_count", 64'(issue_cnt), 64'(base + 4));
      pop_rd();
      wait_issue(base + 5, 20);
      wait_idle(50);
      for (int i = 0; i < 4; i++) begin
         wait_rdq(20);
         pop_rd();
      end
      chk("rdfull_drained", 64'(rdq_valid), 64'd0);

      // Timeout: first write never acknowledged, second still issues
      ack_en = 1'b0;
      base = issue_cnt;
      drive_req(1'b1, 25'h300, 8'h11);
      drive_req(1'b1, 25'h301, 8'h22);
      for (int i = 0; i < 20 && !sd_wr_enable; i++) @(negedge clk);
      cnt = 0;
      while (sd_wr_enable && cnt < 40) begin
         cnt++;
         @(negedge clk);
      end
      ack_en = 1'b1;
      chk("timeout_enable_cycles", 64'(cnt), 64'd15);
      chk("timeout_flag", 64'(err_timeout), 64'd1);
      wait_issue(base + 2, 20);
      wait_idle(50);

      // Reset while a read waits for its data; the late strobe is ignored
      rd_suppress = 1'b1;
      ret_q.push_back(8'h77);
      drive_req(1'b0, 25'h400, 8'h00);
      repeat (10) @(negedge clk);
      chk("wait_data_not_idle", 64'(idle), 64'd0);
      chk("wait_data_addr", 64'(sd_addr), 64'h400);
      rst_n = 1'b0;
      #2;
      chk_reset_outputs("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      rd_suppress = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rdq_valid) bad = 1'b1;
      end
      chk("late_rd_ready_ignored", 64'(bad), 64'd0);
      chk("post_reset_idle", 64'(idle), 64'd1);

      chk("cmd_queue_drained", 64'(exp_cmd.size()), 64'd0);
      chk("rd_queue_drained", 64'(exp_rd.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
